// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative HI/LO multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } mult_state_e;

    localparam int MULT_WIDTH = 32;
    localparam int CNT_W      = $clog2(MULT_WIDTH + 1);

endpackage

// File: rtl/mult_unit.sv
// Multi-cycle shift-add multiplier for MULT/MULTU producing HI/LO.
// Operands are latched as magnitudes; the sign is reapplied on commit.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    mult_state_e          state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        // Carry out of the upper-half add becomes the MSB after the shift.
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_d = {sum, acc_q[WIDTH-1:1]};
        prod  = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    {hi_q, lo_q} <= prod;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed-vector bench for mult_unit: results, timing, start-while-busy,
// mid-operation reset and back-to-back issue.
module tb_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk = 0;
    int n_err = 0;

    mult_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives start for one edge (E0); returns #1 after E0.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        start = 1'b1; a = av; b = bv; is_signed = s;
        @(posedge clk); #1;
        start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    endtask

    // Waits for done; optionally re-pulses start so it is sampled at edge E<glitch>.
    // Returns #1 after the commit edge, i.e. in the done cycle.
    task automatic wait_done(input string tag, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo, input int glitch);
        int edges = 0;
        int busy_cyc = 1;
        logic hold_bad = 1'b0;
        logic [W-1:0] hi0 = hi;
        logic [W-1:0] lo0 = lo;
        chk({tag, " busy@E0"}, {63'd0, busy}, 64'd1);
        while (!done && edges < 100) begin
            if (glitch != 0 && edges == glitch - 1) begin
                start = 1'b1; a = 7; b = 7; is_signed = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0; a = '0; b = '0;
            edges++;
            if (busy) busy_cyc++;
            if (!done && (hi !== hi0 || lo !== lo0)) hold_bad = 1'b1;
        end
        chk({tag, " latency"}, 64'(edges), 64'd33);
        chk({tag, " busy_cycles"}, 64'(busy_cyc), 64'd33);
        chk({tag, " hold"}, {63'd0, hold_bad}, 64'd0);
        chk({tag, " busy@done"}, {63'd0, busy}, 64'd0);
        chk({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    task automatic after_done(input string tag);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, " idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int extra_done;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst done", {63'd0, done}, 64'd0);
        chk("rst hi", {32'd0, hi}, 64'd0);
        chk("rst lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        start_op(32'd3, 32'd5, 1'b0);
        wait_done("u3x5", 32'h0, 32'hF, 0);
        after_done("u3x5");

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("umax", 32'hFFFF_FFFE, 32'h0000_0001, 0);
        after_done("umax");

        start_op(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done("s-1x1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        after_done("s-1x1");

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("s-1x-1", 32'h0, 32'h1, 0);
        after_done("s-1x-1");

        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("sminsq", 32'h4000_0000, 32'h0, 0);
        after_done("sminsq");

        // start pulse sampled at E5 must be ignored
        start_op(32'd3, 32'd5, 1'b0);
        wait_done("glitch", 32'h0, 32'hF, 5);
        after_done("glitch");
        extra_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) extra_done++;
        end
        chk("glitch no_second_op", 64'(extra_done), 64'd0);

        // reset at E10 of a 2*2 following a completed 3*5
        start_op(32'd3, 32'd5, 1'b0);
        wait_done("pre_rst", 32'h0, 32'hF, 0);
        after_done("pre_rst");
        start_op(32'd2, 32'd2, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst done", {63'd0, done}, 64'd0);
        chk("midrst hi", {32'd0, hi}, 64'd0);
        chk("midrst lo", {32'd0, lo}, 64'd0);
        extra_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        chk("midrst no_done", 64'(extra_done), 64'd0);
        start_op(32'd6, 32'd7, 1'b0);
        wait_done("u6x7", 32'h0, 32'd42, 0);
        after_done("u6x7");

        // back-to-back: next start issued in the done cycle
        start_op(32'd3, 32'd5, 1'b0);
        wait_done("b2b_1", 32'h0, 32'hF, 0);
        start_op(32'd2, 32'd9, 1'b0);
        wait_done("b2b_2", 32'h0, 32'd18, 0);
        after_done("b2b_2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
